// File: rtl/pcfg_resp_pkg.sv
// Shared types and constants for the pcfg configuration responder.
package pcfg_resp_pkg;

  typedef enum logic [1:0] {
    SessIdle   = 2'd0,
    SessActive = 2'd1,
    SessDone   = 2'd2
  } sess_state_e;

  localparam int unsigned RegIdxWidthDef = 6;

  // Error causes, used as indices into the per-cycle error tally
  localparam int unsigned ErrOor         = 0;
  localparam int unsigned ErrRwConflict  = 1;
  localparam int unsigned ErrLateWr      = 2;
  localparam int unsigned ErrSpuriousInt = 3;
  localparam int unsigned NumErrCauses   = 4;

endpackage

// File: rtl/pcfg_col_regfile.sv
// One column's config register file: address decode, register array, 1-cycle read port,
// accepted-write and error strobes for the top-level counters.
module pcfg_col_regfile
  import pcfg_resp_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned RegIdxWidth = RegIdxWidthDef
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 wr_acc_o,
  output logic                 err_oor_o,
  output logic                 err_conflict_o
);

  localparam int unsigned NumRegs = 2 ** RegIdxWidth;

  logic [DataWidth-1:0]   regs_q [NumRegs];
  logic [DataWidth-1:0]   regs_d [NumRegs];
  logic [DataWidth-1:0]   rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [RegIdxWidth-1:0] idx;
  logic                   in_range;
  logic                   rd_acc;

  assign idx            = addr_i[RegIdxWidth-1:0];
  assign in_range       = (addr_i[AddrWidth-1:RegIdxWidth] == '0);
  assign wr_acc_o       = wr_en_i & ~rd_en_i & in_range;
  assign rd_acc         = rd_en_i & ~wr_en_i;
  assign err_oor_o      = (wr_en_i ^ rd_en_i) & ~in_range;
  assign err_conflict_o = wr_en_i & rd_en_i;

  always_comb begin
    regs_d = regs_q;
    if (wr_acc_o) regs_d[idx] = data_i;
  end

  // Out-of-range reads still answer, with zero data
  always_comb begin
    rd_valid_d = rd_acc;
    rd_data_d  = rd_data_q;
    if (rd_acc) rd_data_d = in_range ? regs_q[idx] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/pcfg_cfg_responder.sv
// CGRA-side pcfg stream sink: per-column register files, session FSM, write/error counters.
// Optional bitstream signature enabled by defining PCFG_RESP_CHECKSUM_EN.
module pcfg_cfg_responder
  import pcfg_resp_pkg::*;
#(
  parameter int unsigned CGRA_PER_GLB        = 2,
  parameter int unsigned CGRA_CFG_ADDR_WIDTH = 32,
  parameter int unsigned CGRA_CFG_DATA_WIDTH = 32,
  parameter int unsigned REG_IDX_WIDTH       = RegIdxWidthDef,
  parameter int unsigned CNT_WIDTH           = 32,
  parameter int unsigned ERR_WIDTH           = 16
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [CGRA_PER_GLB-1:0]                             cgra_cfg_wr_en,
  input  logic [CGRA_PER_GLB-1:0]                             cgra_cfg_rd_en,
  input  logic [CGRA_PER_GLB-1:0][CGRA_CFG_ADDR_WIDTH-1:0]    cgra_cfg_addr,
  input  logic [CGRA_PER_GLB-1:0][CGRA_CFG_DATA_WIDTH-1:0]    cgra_cfg_data,
  input  logic                                                pcfg_interrupt,
  input  logic                                                session_clr,
  output logic [CGRA_PER_GLB-1:0][CGRA_CFG_DATA_WIDTH-1:0]    cfg_rd_data,
  output logic [CGRA_PER_GLB-1:0]                             cfg_rd_valid,
  output logic [1:0]                                          session_state,
  output logic [CNT_WIDTH-1:0]                                wr_cnt,
  output logic [ERR_WIDTH-1:0]                                err_cnt,
  output logic [CGRA_CFG_DATA_WIDTH-1:0]                      cfg_checksum
);

  localparam logic [1:0] StIdle   = SessIdle;
  localparam logic [1:0] StActive = SessActive;
  localparam logic [1:0] StDone   = SessDone;

  logic [CGRA_PER_GLB-1:0] wr_acc, err_oor, err_conflict;
  logic [1:0]              state_q, state_d;
  logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic [ERR_WIDTH-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH:0]      wr_sum;
  logic [ERR_WIDTH:0]      err_sum;
  int unsigned             n_wr, n_err;
  int unsigned             err_by_cause [NumErrCauses];

  for (genvar c = 0; c < CGRA_PER_GLB; c++) begin : g_col
    pcfg_col_regfile #(
      .AddrWidth  (CGRA_CFG_ADDR_WIDTH),
      .DataWidth  (CGRA_CFG_DATA_WIDTH),
      .RegIdxWidth(REG_IDX_WIDTH)
    ) u_col (
      .clk_i         (clk),
      .rst_i         (reset),
      .wr_en_i       (cgra_cfg_wr_en[c]),
      .rd_en_i       (cgra_cfg_rd_en[c]),
      .addr_i        (cgra_cfg_addr[c]),
      .data_i        (cgra_cfg_data[c]),
      .rd_data_o     (cfg_rd_data[c]),
      .rd_valid_o    (cfg_rd_valid[c]),
      .wr_acc_o      (wr_acc[c]),
      .err_oor_o     (err_oor[c]),
      .err_conflict_o(err_conflict[c])
    );
  end

  always_comb begin
    n_wr = 0;
    for (int i = 0; i < NumErrCauses; i++) err_by_cause[i] = 0;
    for (int c = 0; c < CGRA_PER_GLB; c++) begin
      n_wr                        = n_wr + 32'(wr_acc[c]);
      err_by_cause[ErrOor]        = err_by_cause[ErrOor] + 32'(err_oor[c]);
      err_by_cause[ErrRwConflict] = err_by_cause[ErrRwConflict] + 32'(err_conflict[c]);
    end
    err_by_cause[ErrLateWr]      = (state_q == StDone) ? n_wr : 0;
    err_by_cause[ErrSpuriousInt] = 32'(pcfg_interrupt && (state_q == StIdle));
    n_err = 0;
    for (int i = 0; i < NumErrCauses; i++) n_err = n_err + err_by_cause[i];

    wr_sum    = {1'b0, wr_cnt_q} + (CNT_WIDTH+1)'(n_wr);
    err_sum   = {1'b0, err_cnt_q} + (ERR_WIDTH+1)'(n_err);
    wr_cnt_d  = wr_sum[CNT_WIDTH] ? '1 : wr_sum[CNT_WIDTH-1:0];
    err_cnt_d = err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];

    state_d = state_q;
    case (state_q)
      StIdle:   if (n_wr != 0) state_d = StActive;
      StActive: if (pcfg_interrupt) state_d = StDone;
      StDone:   state_d = StDone;
      default:  state_d = StIdle;
    endcase

    // Clear wins over everything except the register-file writes themselves
    if (session_clr) begin
      state_d   = StIdle;
      wr_cnt_d  = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign session_state = state_q;
  assign wr_cnt        = wr_cnt_q;
  assign err_cnt       = err_cnt_q;

`ifdef PCFG_RESP_CHECKSUM_EN
  logic [CGRA_CFG_DATA_WIDTH-1:0] cs_q, cs_d;

  always_comb begin
    cs_d = cs_q;
    for (int c = 0; c < CGRA_PER_GLB; c++) begin
      if (wr_acc[c]) begin
        cs_d = {cs_d[CGRA_CFG_DATA_WIDTH-2:0], cs_d[CGRA_CFG_DATA_WIDTH-1]} ^ cgra_cfg_data[c]
               ^ CGRA_CFG_DATA_WIDTH'(cgra_cfg_addr[c]);
      end
    end
    if (session_clr) cs_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cs_q <= '0;
    else       cs_q <= cs_d;
  end

  assign cfg_checksum = cs_q;
`else
  assign cfg_checksum = '0;
`endif

endmodule

// File: tb/tb_pcfg_cfg_responder.sv
// Directed self-checking bench for pcfg_cfg_responder (default parameters).
module tb_pcfg_cfg_responder;

  logic              clk;
  logic              reset;
  logic [1:0]        wr_en, rd_en;
  logic [1:0][31:0]  addr, data;
  logic              pcfg_interrupt, session_clr;
  logic [1:0][31:0]  rd_data;
  logic [1:0]        rd_valid;
  logic [1:0]        state;
  logic [31:0]       wr_cnt;
  logic [15:0]       err_cnt;
  logic [31:0]       checksum;

  int checks = 0;
  int errors = 0;

  pcfg_cfg_responder dut (
    .clk           (clk),
    .reset         (reset),
    .cgra_cfg_wr_en(wr_en),
    .cgra_cfg_rd_en(rd_en),
    .cgra_cfg_addr (addr),
    .cgra_cfg_data (data),
    .pcfg_interrupt(pcfg_interrupt),
    .session_clr   (session_clr),
    .cfg_rd_data   (rd_data),
    .cfg_rd_valid  (rd_valid),
    .session_state (state),
    .wr_cnt        (wr_cnt),
    .err_cnt       (err_cnt),
    .cfg_checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = '0; rd_en = '0; addr = '0; data = '0;
    pcfg_interrupt = 1'b0; session_clr = 1'b0;
  endtask

  task automatic do_write(input int col, input logic [31:0] a, input logic [31:0] d);
    idle_inputs();
    wr_en[col] = 1'b1; addr[col] = a; data[col] = d;
    cyc();
    idle_inputs();
  endtask

  task automatic do_read(input int col, input logic [31:0] a);
    idle_inputs();
    rd_en[col] = 1'b1; addr[col] = a;
    cyc();
    idle_inputs();
  endtask

  task automatic do_clr();
    idle_inputs();
    session_clr = 1'b1;
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if (state !== 2'd0 || wr_cnt !== 32'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters state=%0d wr=%0d err=%0d want 0 0 0", state, wr_cnt, err_cnt);
    end
    checks++;
    if (rd_valid !== 2'b00 || rd_data !== 64'd0 || checksum !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b data=%h cs=%h want 0", rd_valid, rd_data, checksum);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    do_write(0, 32'h05, 32'hDEAD_BEEF);
    do_read(0, 32'h05);
    checks++;
    if (rd_valid !== 2'b01 || rd_data[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_rd valid=%b data=%h want 01 deadbeef", rd_valid, rd_data[0]);
    end
    checks++;
    if (wr_cnt !== 32'd1 || state !== 2'd1) begin
      errors++;
      $display("FAIL wr_rd_session wr=%0d state=%0d want 1 1", wr_cnt, state);
    end
    cyc();
    checks++;
    if (rd_valid !== 2'b00 || rd_data[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_hold valid=%b data=%h want 00 deadbeef", rd_valid, rd_data[0]);
    end
  endtask

  task automatic test_multi_col();
    do_clr();
    wr_en = 2'b11;
    addr[0] = 32'h01; data[0] = 32'h11;
    addr[1] = 32'h01; data[1] = 32'h22;
    cyc();
    idle_inputs();
    rd_en = 2'b11; addr[0] = 32'h01; addr[1] = 32'h01;
    cyc();
    idle_inputs();
    checks++;
    if (rd_valid !== 2'b11 || rd_data[0] !== 32'h11 || rd_data[1] !== 32'h22) begin
      errors++;
      $display("FAIL multi_col valid=%b d0=%h d1=%h want 11 11 22", rd_valid, rd_data[0],
               rd_data[1]);
    end
    checks++;
    if (wr_cnt !== 32'd2) begin
      errors++;
      $display("FAIL multi_col_cnt wr=%0d want 2", wr_cnt);
    end
  endtask

  task automatic test_errors();
    do_clr();
    do_write(1, 32'h00, 32'h55);
    do_write(1, 32'h40, 32'h99);
    checks++;
    if (err_cnt !== 16'd1 || wr_cnt !== 32'd1) begin
      errors++;
      $display("FAIL oor_write err=%0d wr=%0d want 1 1", err_cnt, wr_cnt);
    end
    do_read(1, 32'h00);
    checks++;
    if (rd_valid[1] !== 1'b1 || rd_data[1] !== 32'h55) begin
      errors++;
      $display("FAIL oor_no_update valid=%b data=%h want 1 55", rd_valid[1], rd_data[1]);
    end
    idle_inputs();
    wr_en[0] = 1'b1; rd_en[0] = 1'b1; addr[0] = 32'h05; data[0] = 32'h1234;
    cyc();
    idle_inputs();
    checks++;
    if (rd_valid !== 2'b00 || err_cnt !== 16'd2 || wr_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rw_conflict valid=%b err=%0d wr=%0d want 00 2 1", rd_valid, err_cnt, wr_cnt);
    end
    do_read(0, 32'h05);
    checks++;
    if (rd_data[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL conflict_no_write data=%h want deadbeef", rd_data[0]);
    end
    do_read(0, 32'h105);
    checks++;
    if (rd_valid !== 2'b01 || rd_data[0] !== 32'h0 || err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL oor_read valid=%b data=%h err=%0d want 01 0 3", rd_valid, rd_data[0],
               err_cnt);
    end
  endtask

  task automatic test_session();
    do_clr();
    checks++;
    if (state !== 2'd0 || wr_cnt !== 32'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr state=%0d wr=%0d err=%0d want 0 0 0", state, wr_cnt, err_cnt);
    end
    for (int i = 0; i < 10; i++) do_write(0, 32'(i), 32'(i));
    pcfg_interrupt = 1'b1;
    cyc();
    idle_inputs();
    checks++;
    if (state !== 2'd2 || wr_cnt !== 32'd10 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL done state=%0d wr=%0d err=%0d want 2 10 0", state, wr_cnt, err_cnt);
    end
    do_write(0, 32'h3F, 32'hAB);
    checks++;
    if (state !== 2'd2 || wr_cnt !== 32'd11 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL late_wr state=%0d wr=%0d err=%0d want 2 11 1", state, wr_cnt, err_cnt);
    end
    pcfg_interrupt = 1'b1;
    cyc();
    idle_inputs();
    checks++;
    if (state !== 2'd2 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL int_in_done state=%0d err=%0d want 2 1", state, err_cnt);
    end
    do_clr();
    checks++;
    if (state !== 2'd0 || wr_cnt !== 32'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL done_clr state=%0d wr=%0d err=%0d want 0 0 0", state, wr_cnt, err_cnt);
    end
    do_read(0, 32'h03);
    checks++;
    if (rd_data[0] !== 32'h3) begin
      errors++;
      $display("FAIL kept_after_clr data=%h want 3", rd_data[0]);
    end
    do_read(0, 32'h3F);
    checks++;
    if (rd_data[0] !== 32'hAB) begin
      errors++;
      $display("FAIL late_wr_applied data=%h want ab", rd_data[0]);
    end
    pcfg_interrupt = 1'b1;
    cyc();
    idle_inputs();
    checks++;
    if (state !== 2'd0 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL spurious_int state=%0d err=%0d want 0 1", state, err_cnt);
    end
    // Write and interrupt together while active: counted, then DONE
    do_write(1, 32'h02, 32'h2);
    wr_en[1] = 1'b1; addr[1] = 32'h03; data[1] = 32'h3; pcfg_interrupt = 1'b1;
    cyc();
    idle_inputs();
    checks++;
    if (state !== 2'd2 || wr_cnt !== 32'd2 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL wr_with_int state=%0d wr=%0d err=%0d want 2 2 1", state, wr_cnt, err_cnt);
    end
  endtask

  task automatic test_clr_priority();
    do_clr();
    session_clr = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h07; data[0] = 32'h77;
    cyc();
    idle_inputs();
    checks++;
    if (state !== 2'd0 || wr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL clr_priority state=%0d wr=%0d want 0 0", state, wr_cnt);
    end
    do_read(0, 32'h07);
    checks++;
    if (rd_data[0] !== 32'h77) begin
      errors++;
      $display("FAIL clr_wr_applied data=%h want 77", rd_data[0]);
    end
  endtask

  task automatic test_checksum();
    do_clr();
    do_write(0, 32'h0, 32'h1);
`ifdef PCFG_RESP_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h1) begin
      errors++;
      $display("FAIL checksum_1 got=%h want 00000001", checksum);
    end
`endif
    do_write(0, 32'h1, 32'h2);
`ifdef PCFG_RESP_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h1) begin
      errors++;
      $display("FAIL checksum_2 got=%h want 00000001", checksum);
    end
    do_clr();
    wr_en = 2'b11;
    addr[0] = 32'h0; data[0] = 32'h1;
    addr[1] = 32'h1; data[1] = 32'h2;
    cyc();
    idle_inputs();
    checks++;
    if (checksum !== 32'h1) begin
      errors++;
      $display("FAIL checksum_order got=%h want 00000001", checksum);
    end
`else
    checks++;
    if (checksum !== 32'h0) begin
      errors++;
      $display("FAIL checksum_off got=%h want 0", checksum);
    end
`endif
  endtask

  task automatic test_mid_reset();
    do_clr();
    do_write(1, 32'd10, 32'hA);
    do_write(1, 32'd11, 32'hB);
    do_write(1, 32'd12, 32'hC);
    checks++;
    if (wr_cnt !== 32'd3 || state !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset wr=%0d state=%0d want 3 1", wr_cnt, state);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || wr_cnt !== 32'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset state=%0d wr=%0d err=%0d want 0 0 0", state, wr_cnt, err_cnt);
    end
    cyc();
    reset = 1'b0;
    do_read(1, 32'd10);
    checks++;
    if (rd_valid[1] !== 1'b1 || rd_data[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_regfile valid=%b data=%h want 1 0", rd_valid[1], rd_data[1]);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_multi_col();
    test_errors();
    test_session();
    test_clr_priority();
    test_checksum();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
